// File: rtl/d_phy_pkg.sv
// Shared D-PHY definitions: transmitter FSM states and the HS sync byte,
// reused by the receiver-side blocks.
package d_phy_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ZERO  = 3'd1,
        SYNC  = 3'd2,
        DATA  = 3'd3,
        TRAIL = 3'd4
    } dphy_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

endpackage

// File: rtl/d_phy_byte_serializer.sv
// Byte-to-DDR-pair serializer: a load presents bits [1:0] on the next clock,
// each shift presents the next LSB-first pair, otherwise both lines hold fill_level.
module d_phy_byte_serializer
    import d_phy_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       shift,
    input  logic       fill_level,
    output logic       data_h,
    output logic       data_l
);

    logic [5:0] rest_q, rest_d;
    logic       data_h_q, data_h_d;
    logic       data_l_q, data_l_d;

    always_comb begin
        rest_d   = rest_q;
        data_h_d = fill_level;
        data_l_d = fill_level;
        if (load) begin
            data_h_d = load_byte[0];
            data_l_d = load_byte[1];
            rest_d   = load_byte[7:2];
        end else if (shift) begin
            data_h_d = rest_q[0];
            data_l_d = rest_q[1];
            rest_d   = {2'b00, rest_q[5:2]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rest_q   <= '0;
            data_h_q <= 1'b0;
            data_l_q <= 1'b0;
        end else begin
            rest_q   <= rest_d;
            data_h_q <= data_h_d;
            data_l_q <= data_l_d;
        end
    end

    assign data_h = data_h_q;
    assign data_l = data_l_q;

endmodule

// File: rtl/d_phy_transmitter.sv
// D-PHY HS lane transmitter: HS-zero, sync byte, back-to-back payload bytes,
// then HS-trail at the inverse of the last line bit. Two line bits per clock.
module d_phy_transmitter
    import d_phy_pkg::*;
#(
    parameter int HS_ZERO_CYCLES  = 8,
    parameter int HS_TRAIL_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       data_h,
    output logic       data_l,
    output logic       hs_enable,
    output logic       burst_end
);

    localparam logic [7:0] ZERO_LAST  = 8'(HS_ZERO_CYCLES - 1);
    localparam logic [7:0] TRAIL_LAST = 8'(HS_TRAIL_CYCLES - 1);

    dphy_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  pair_q, pair_d;
    logic [7:0]  hold_q, hold_d;
    logic        hs_enable_q, hs_enable_d;
    logic        burst_end_q, burst_end_d;

    logic        ser_load;
    logic [7:0]  ser_byte;
    logic        ser_shift;
    logic        ser_fill;
    logic        transfer;

    // Gated by reset so the handshake stays closed while the block is held in reset.
    always_comb begin
        byte_ready = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE:    byte_ready = 1'b1;
                DATA:    byte_ready = (pair_q == 2'd3);
                default: byte_ready = 1'b0;
            endcase
        end
    end

    assign transfer = byte_valid & byte_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pair_d    = pair_q;
        hold_d    = hold_q;
        ser_load  = 1'b0;
        ser_byte  = hold_q;
        ser_shift = 1'b0;
        ser_fill  = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    hold_d  = byte_data;
                    cnt_d   = '0;
                    state_d = ZERO;
                end
            end
            ZERO: begin
                if (cnt_q == ZERO_LAST) begin
                    state_d  = SYNC;
                    ser_load = 1'b1;
                    ser_byte = SYNC_BYTE;
                    pair_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SYNC: begin
                if (pair_q == 2'd3) begin
                    state_d  = DATA;
                    ser_load = 1'b1;
                    ser_byte = hold_q;
                    pair_d   = '0;
                end else begin
                    ser_shift = 1'b1;
                    pair_d    = pair_q + 2'd1;
                end
            end
            DATA: begin
                if (pair_q != 2'd3) begin
                    ser_shift = 1'b1;
                    pair_d    = pair_q + 2'd1;
                end else if (transfer) begin
                    hold_d   = byte_data;
                    ser_load = 1'b1;
                    ser_byte = byte_data;
                    pair_d   = '0;
                end else begin
                    // Missed byte slot: trail level is the inverse of the last bit on the line.
                    state_d  = TRAIL;
                    cnt_d    = '0;
                    ser_fill = ~data_l;
                end
            end
            TRAIL: begin
                ser_fill = data_h;
                if (cnt_q == TRAIL_LAST) begin
                    state_d  = IDLE;
                    ser_fill = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        hs_enable_d = (state_d != IDLE);
        burst_end_d = (state_q == TRAIL) && (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pair_q      <= '0;
            hold_q      <= '0;
            hs_enable_q <= 1'b0;
            burst_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pair_q      <= pair_d;
            hold_q      <= hold_d;
            hs_enable_q <= hs_enable_d;
            burst_end_q <= burst_end_d;
        end
    end

    d_phy_byte_serializer u_serializer (
        .clock      (clock),
        .reset      (reset),
        .load       (ser_load),
        .load_byte  (ser_byte),
        .shift      (ser_shift),
        .fill_level (ser_fill),
        .data_h     (data_h),
        .data_l     (data_l)
    );

    assign hs_enable = hs_enable_q;
    assign burst_end = burst_end_q;

endmodule

// File: tb/tb_d_phy_transmitter.sv
// Directed bench for d_phy_transmitter: per-cycle vector table for a single
// byte, plus captured-burst sequences for multi-byte, parameter and reset cases.
module tb_d_phy_transmitter;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, h0, l0, hs0, end0;
    logic       ready1, h1, l1, hs1, end1;

    always #5 clock = ~clock;

    d_phy_transmitter dut0 (
        .clock      (clock),
        .reset      (reset),
        .byte_data  (data0),
        .byte_valid (valid0),
        .byte_ready (ready0),
        .data_h     (h0),
        .data_l     (l0),
        .hs_enable  (hs0),
        .burst_end  (end0)
    );

    d_phy_transmitter #(.HS_ZERO_CYCLES(9), .HS_TRAIL_CYCLES(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .byte_data  (data1),
        .byte_valid (valid1),
        .byte_ready (ready1),
        .data_h     (h1),
        .data_l     (l1),
        .hs_enable  (hs1),
        .burst_end  (end1)
    );

    logic sel;
    logic cur_ready, cur_h, cur_l, cur_hs, cur_end;
    assign cur_ready = sel ? ready1 : ready0;
    assign cur_h     = sel ? h1     : h0;
    assign cur_l     = sel ? l1     : l0;
    assign cur_hs    = sel ? hs1    : hs0;
    assign cur_end   = sel ? end1   : end0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [23];

    logic       cap_h[$], cap_l[$], cap_rdy[$], cap_hs[$], cap_end[$];
    logic [7:0] tx_q[$];
    logic [7:0] sent_q[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [4:0] e);
        vec_t r;
        r.valid = v;
        r.data  = d;
        r.exp   = e;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        valid0 = v.valid;
        data0  = v.data;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (sel) begin
            valid1 = v;
            data1  = d;
        end else begin
            valid0 = v;
            data0  = d;
        end
    endtask

    // Feed tx_q through the handshake and record one sample per clock until burst_end.
    task automatic run_capture(input int max_cycles);
        bit   ended = 1'b0;
        logic pre;
        cap_h.delete(); cap_l.delete(); cap_rdy.delete(); cap_hs.delete(); cap_end.delete();
        for (int c = 0; c < max_cycles && !ended; c++) begin
            if (tx_q.size() > 0) drive(1'b1, tx_q[0]);
            else                 drive(1'b0, 8'h00);
            pre = cur_ready;
            @(posedge clock);
            #1;
            if (pre && tx_q.size() > 0) void'(tx_q.pop_front());
            cap_h.push_back(cur_h);
            cap_l.push_back(cur_l);
            cap_rdy.push_back(cur_ready);
            cap_hs.push_back(cur_hs);
            cap_end.push_back(cur_end);
            if (cur_end) ended = 1'b1;
        end
        drive(1'b0, 8'h00);
        checkOutput("capture_reached_burst_end", int'(ended), 1);
    endtask

    task automatic check_burst(input int hz, input int ht, input string tag);
        int         n;
        int         len;
        int         mism;
        int         first_bad;
        int         hs_count;
        int         end_count;
        int         end_index;
        int         rdy_mism;
        logic       expb[$];
        logic [7:0] sync_byte;
        logic [7:0] tmp;
        logic       last_bit;
        logic       exp_rdy;
        n         = sent_q.size();
        len       = hz + 4 + 4 * n + ht;
        sync_byte = 8'hB8;
        last_bit  = 1'b0;
        for (int i = 0; i < 2 * hz; i++) expb.push_back(1'b0);
        for (int b = 0; b < 8; b++) expb.push_back(sync_byte[b]);
        for (int k = 0; k < n; k++) begin
            tmp = sent_q[k];
            for (int b = 0; b < 8; b++) expb.push_back(tmp[b]);
            last_bit = tmp[7];
        end
        for (int i = 0; i < 2 * ht; i++) expb.push_back(~last_bit);

        checkOutput({tag, "_capture_len"}, cap_h.size(), len + 1);

        mism = 0;
        first_bad = -1;
        rdy_mism = 0;
        for (int c = 0; c < len && c < cap_h.size(); c++) begin
            if (cap_h[c] !== expb[2 * c] || cap_l[c] !== expb[2 * c + 1]) begin
                mism++;
                if (first_bad < 0) first_bad = c;
            end
            exp_rdy = (c >= hz + 4) && (c < hz + 4 + 4 * n) && (((c - hz - 4) % 4) == 3);
            if (cap_rdy[c] !== exp_rdy) rdy_mism++;
        end
        if (mism != 0) $display("[TB] %s first bad line pair at cycle %0d", tag, first_bad);
        checkOutput({tag, "_line_bits_mismatches"}, mism, 0);
        checkOutput({tag, "_ready_pattern_mismatches"}, rdy_mism, 0);

        hs_count  = 0;
        end_count = 0;
        end_index = -1;
        for (int c = 0; c < cap_hs.size(); c++) begin
            if (cap_hs[c] === 1'b1) hs_count++;
            if (cap_end[c] === 1'b1) begin
                end_count++;
                if (end_index < 0) end_index = c;
            end
        end
        checkOutput({tag, "_hs_enable_width"}, hs_count, len);
        checkOutput({tag, "_burst_end_count"}, end_count, 1);
        checkOutput({tag, "_burst_end_cycle"}, end_index, len);
        if (cap_rdy.size() > len) checkOutput({tag, "_ready_on_burst_end"}, int'(cap_rdy[len]), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ends_seen;
        int hs_seen;

        vecs[0] = mk(1'b1, 8'h5A, 5'b00010);
        for (int i = 1; i <= 8; i++) vecs[i] = mk(1'b1, 8'hA5, 5'b00010);
        vecs[9]  = mk(1'b1, 8'hA5, 5'b00110);
        vecs[10] = mk(1'b1, 8'hA5, 5'b01110);
        vecs[11] = mk(1'b1, 8'hA5, 5'b00110);
        vecs[12] = mk(1'b1, 8'hA5, 5'b00110);
        vecs[13] = mk(1'b1, 8'hA5, 5'b00110);
        vecs[14] = mk(1'b1, 8'hA5, 5'b01010);
        vecs[15] = mk(1'b1, 8'hA5, 5'b11010);
        vecs[16] = mk(1'b0, 8'h00, 5'b01110);
        for (int i = 17; i <= 19; i++) vecs[i] = mk(1'b1, 8'hFF, 5'b01110);
        vecs[20] = mk(1'b1, 8'hFF, 5'b10001);
        vecs[21] = mk(1'b0, 8'h00, 5'b10000);
        vecs[22] = mk(1'b0, 8'h00, 5'b10000);

        sel    = 1'b0;
        reset  = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0  = 8'h00;
        data1  = 8'h00;

        #12;
        checkOutput("reset_outputs_dut0", int'({ready0, h0, l0, hs0, end0}), 0);
        checkOutput("reset_outputs_dut1", int'({ready1, h1, l1, hs1, end1}), 0);
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("ready_after_release", int'({ready0, h0, l0, hs0, end0}), 5'b10000);

        $display("[TB] single byte 5A vector table");
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), int'({ready0, h0, l0, hs0, end0}), int'(vecs[i].exp));
        end

        $display("[TB] burst 01 02 03");
        tx_q = '{8'h01, 8'h02, 8'h03};
        sent_q = tx_q;
        run_capture(300);
        check_burst(8, 4, "burst3");

        $display("[TB] valid drops after two bytes, third byte back-to-back");
        tx_q = '{8'h11, 8'h22};
        sent_q = tx_q;
        run_capture(300);
        check_burst(8, 4, "drop2");
        tx_q = '{8'h33};
        sent_q = tx_q;
        run_capture(300);
        check_burst(8, 4, "third");

        $display("[TB] 16 random bytes");
        tx_q.delete();
        for (int i = 0; i < 16; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        sent_q = tx_q;
        run_capture(400);
        check_burst(8, 4, "rand16");

        $display("[TB] HS_ZERO_CYCLES=9 HS_TRAIL_CYCLES=1 byte FF");
        sel = 1'b1;
        tx_q = '{8'hFF};
        sent_q = tx_q;
        run_capture(300);
        check_burst(9, 1, "p9t1");
        sel = 1'b0;

        $display("[TB] reset in DATA pair 2");
        @(posedge clock);
        #1;
        valid0 = 1'b1;
        data0  = 8'h5A;
        @(posedge clock);
        #1;
        valid0 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clock);
            #1;
        end
        checkOutput("pre_reset_pair2", int'({ready0, h0, l0, hs0, end0}), 5'b01010);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_async_outputs", int'({ready0, h0, l0, hs0, end0}), 0);
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("ready_after_abort", int'({ready0, end0, hs0}), 3'b100);
        ends_seen = 0;
        hs_seen   = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock);
            #1;
            if (end0) ends_seen++;
            if (hs0) hs_seen++;
        end
        checkOutput("no_burst_end_after_abort", ends_seen, 0);
        checkOutput("no_hs_after_abort", hs_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
